// File: rtl/pool_window_gather_pkg.sv
// Shared constants and types for the 2x2 max-pool window gather block.
package pool_window_gather_pkg;

    // Channels per pixel produced by the conv layer.
    localparam int unsigned CHANNEL_OUT = 2;

    // Bits per channel sample (signed, passed through untouched).
    localparam int unsigned PIX_W = 8;

    // Value presented on curr_state_or while a window is valid; enables the pool stage.
    localparam logic [2:0] POOL_EN_STATE = 3'd4;

    // Frame-level control states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } gather_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: IMG_W pixel slots, single write port, two combinational read ports.
module pool_line_buf
    import pool_window_gather_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned DW    = CHANNEL_OUT * PIX_W,
    localparam int unsigned AW   = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DW-1:0] mem [IMG_W];

    // Write the even-row pixel into its column slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Both read ports are combinational so the window can load in the same cycle.
    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
    end

endmodule

// File: rtl/pool_window_gather.sv
// Gathers a row-major pixel stream into non-overlapping 2x2 windows for the max-pool stage.
module pool_window_gather
    import pool_window_gather_pkg::*;
#(
    parameter int unsigned CH    = CHANNEL_OUT,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*PIX_W-1:0]   in_pixel,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [CH*2*PIX_W-1:0] pixel_1and2,
    output logic [CH*PIX_W-1:0]   pixel_3,
    output logic [CH*PIX_W-1:0]   pixel_4,
    output logic [2:0]            curr_state_or,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned DW = CH * PIX_W;
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    gather_state_e state_q, state_d;

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DW-1:0]   bl_q;
    logic [2*DW-1:0] p12_q;
    logic [DW-1:0]   p3_q, p4_q;
    logic            win_valid_q, win_valid_d;
    logic            frame_done_q;

    logic            accept;
    logic            win_fire;
    logic            last_pix;
    logic            lb_we;
    logic            win_load;
    logic            bl_load;
    logic [CW-1:0]   lb_addr_left;
    logic [DW-1:0]   lb_left, lb_right;
    logic [2*DW-1:0] top_pair;

    // Handshake and decode of where the current beat lands.
    always_comb begin
        in_ready = (state_q == StRun) & (~win_valid_q | win_ready);
        accept   = in_valid & in_ready;
        win_fire = win_valid_q & win_ready;
        last_pix = accept & (row_q == ROW_LAST) & (col_q == COL_LAST);
        lb_we    = accept & ~row_q[0];
        bl_load  = accept & row_q[0] & ~col_q[0];
        win_load = accept & row_q[0] & col_q[0];
        // col is odd when the left read matters, so clearing bit 0 gives col-1.
        lb_addr_left = col_q & ~CW'(1);
    end

    pool_line_buf #(
        .IMG_W (IMG_W),
        .DW    (DW)
    ) u_line_buf (
        .clk     (clk),
        .we      (lb_we),
        .waddr   (col_q),
        .wdata   (in_pixel),
        .raddr_a (lb_addr_left),
        .raddr_b (col_q),
        .rdata_a (lb_left),
        .rdata_b (lb_right)
    );

    // Interleave top-left/top-right per channel into the pixel_1and2 layout.
    always_comb begin
        top_pair = '0;
        for (int c = 0; c < int'(CH); c++) begin
            top_pair[c*2*PIX_W +: PIX_W]         = lb_left[c*PIX_W +: PIX_W];
            top_pair[c*2*PIX_W + PIX_W +: PIX_W] = lb_right[c*PIX_W +: PIX_W];
        end
    end

    // Frame FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start)    state_d = StRun;
            StRun:   if (last_pix) state_d = StDrain;
            StDrain: if (win_fire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Row/column position of the next beat; parked at 0,0 while idle.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == StIdle) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // A new window wins over a consume in the same cycle, giving back-to-back windows.
    always_comb begin
        win_valid_d = win_valid_q;
        if (win_load) begin
            win_valid_d = 1'b1;
        end else if (win_fire) begin
            win_valid_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= (state_q == StDrain) & win_fire;
        end
    end

    // Window data registers; they only change on a load, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_q  <= '0;
            p12_q <= '0;
            p3_q  <= '0;
            p4_q  <= '0;
        end else begin
            if (bl_load) begin
                bl_q <= in_pixel;
            end
            if (win_load) begin
                p12_q <= top_pair;
                p3_q  <= bl_q;
                p4_q  <= in_pixel;
            end
        end
    end

    // Output drive.
    always_comb begin
        win_valid     = win_valid_q;
        pixel_1and2   = p12_q;
        pixel_3       = p3_q;
        pixel_4       = p4_q;
        curr_state_or = win_valid_q ? POOL_EN_STATE : 3'd0;
        busy          = (state_q != StIdle);
        frame_done    = frame_done_q;
    end

endmodule

// File: tb/tb_pool_window_gather.sv
// Randomized bench for pool_window_gather with a 2x2 gather reference model and scoreboard.
module tb_pool_window_gather;
    import pool_window_gather_pkg::*;

    localparam int unsigned CH     = CHANNEL_OUT;
    localparam int unsigned IMG_W  = 8;
    localparam int unsigned IMG_H  = 8;
    localparam int unsigned DW     = CH * PIX_W;
    localparam int          NPIX   = IMG_W * IMG_H;
    localparam int          NWIN   = (IMG_W / 2) * (IMG_H / 2);
    localparam int          BUDGET = 3000;

    typedef struct packed {
        logic [2*DW-1:0] p12;
        logic [DW-1:0]   p3;
        logic [DW-1:0]   p4;
    } win_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_pixel;
    logic            win_valid;
    logic            win_ready;
    logic [2*DW-1:0] pixel_1and2;
    logic [DW-1:0]   pixel_3;
    logic [DW-1:0]   pixel_4;
    logic [2:0]      curr_state_or;
    logic            busy;
    logic            frame_done;

    int n_checks = 0;
    int n_errors = 0;

    pool_window_gather #(
        .CH    (CH),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .pixel_1and2   (pixel_1and2),
        .pixel_3       (pixel_3),
        .pixel_4       (pixel_4),
        .curr_state_or (curr_state_or),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_p12"}, pixel_1and2, 0);
        check({tag, "_p3"}, pixel_3, 0);
        check({tag, "_p4"}, pixel_4, 0);
        check({tag, "_pool_en"}, curr_state_or, 0);
    endtask

    // Runs one frame; abort_at>0 stops after that many RUN cycles without end-of-frame checks.
    task automatic run_frame(input int v_pct, input int r_pct, input int stall, input bit directed,
                             input int abort_at, input bit chk_tput);
        logic [DW-1:0] img [NPIX];
        win_t exp_q[$];
        win_t w, got, prev;
        bit   prev_hold, done, aborted;
        int   pix, nwin, iter, acc_last, stall_left;

        for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
        if (directed) begin
            img[0]         = 16'hFF01;
            img[1]         = 16'hFE02;
            img[IMG_W]     = 16'hFD03;
            img[IMG_W + 1] = 16'hFC04;
        end

        // Reference: every non-overlapping 2x2 block, emitted in raster order of blocks.
        for (int wr = 0; wr < int'(IMG_H) / 2; wr++) begin
            for (int wc = 0; wc < int'(IMG_W) / 2; wc++) begin
                logic [DW-1:0] tl, tr, bl, br;
                tl = img[(2*wr)*IMG_W + 2*wc];
                tr = img[(2*wr)*IMG_W + 2*wc + 1];
                bl = img[(2*wr+1)*IMG_W + 2*wc];
                br = img[(2*wr+1)*IMG_W + 2*wc + 1];
                for (int c = 0; c < int'(CH); c++) begin
                    w.p12[c*16 +: 8]     = tl[c*8 +: 8];
                    w.p12[c*16 + 8 +: 8] = tr[c*8 +: 8];
                end
                w.p3 = bl;
                w.p4 = br;
                exp_q.push_back(w);
            end
        end

        // Input offered while idle must be refused.
        @(posedge clk); #1;
        win_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = DW'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_busy", busy, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        pix = 0; nwin = 0; iter = 0; acc_last = -1; stall_left = stall;
        prev_hold = 0; done = 0; aborted = 0; prev = '0;
        while (!done && !aborted && iter < BUDGET) begin
            in_valid = (pix < NPIX) && ($urandom_range(99) < v_pct);
            in_pixel = (pix < NPIX) ? img[pix] : DW'($urandom);
            if (win_valid && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = ($urandom_range(99) < r_pct);
            end
            // Start pulses while busy must be ignored.
            start = busy && ($urandom_range(15) == 0);

            @(negedge clk);
            got = {pixel_1and2, pixel_3, pixel_4};
            if (prev_hold) check("hold_stable", got, prev);
            if (win_valid && !win_ready) check("in_ready_stall", in_ready, 0);
            if (!win_valid) check("pool_en_off", curr_state_or, 0);
            if (in_valid && in_ready) begin
                pix++;
                if (chk_tput && pix == NPIX) check("tput_cycles", iter + 1, NPIX);
            end
            if (win_valid && win_ready) begin
                check("pool_en_on", curr_state_or, 3'd4);
                if (exp_q.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("p12", pixel_1and2, w.p12);
                    check("p3", pixel_3, w.p3);
                    check("p4", pixel_4, w.p4);
                    if (directed && nwin == 0) begin
                        check("dir_p12", pixel_1and2, 32'hFEFF0201);
                        check("dir_p3", pixel_3, 16'hFD03);
                        check("dir_p4", pixel_4, 16'hFC04);
                    end
                end
                nwin++;
                if (nwin == NWIN) begin
                    check("frame_done_early", frame_done, 0);
                    acc_last = iter;
                end
            end
            if (frame_done) begin
                check("frame_done_timing", iter, acc_last + 1);
                check("busy_after", busy, 0);
                check("in_ready_after", in_ready, 0);
                done = 1;
            end
            prev_hold = win_valid && !win_ready;
            prev      = got;
            if (abort_at > 0 && iter + 1 >= abort_at) aborted = 1;
            if (!done && !aborted) begin
                @(posedge clk); #1;
            end
            iter++;
        end
        in_valid  = 1'b0;
        win_ready = 1'b0;
        start     = 1'b0;

        if (!aborted) begin
            check("frame_done_seen", done, 1);
            check("windows", nwin, NWIN);
            check("pixels", pix, NPIX);
            check("leftover", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = '0;
        win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed first window plus full-throughput frame.
        run_frame(100, 100, 0, 1'b1, 0, 1'b1);
        // Downstream stalls on the first window.
        run_frame(100, 100, 5, 1'b0, 0, 1'b0);
        // Partial frame cut short by reset, then a clean frame.
        run_frame(100, 50, 0, 1'b0, 30, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(100, 100, 0, 1'b0, 0, 1'b0);
        // Random gaps on both sides over several frames.
        for (int f = 0; f < 3; f++) run_frame(50, 50, 0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
